// File: rtl/spi_slave_fullduplex.sv
// Mode-0 SPI slave, MSB first, oversampled in the clk domain. rx_data/tx_data are parallel words.
// Optional build macro SPI_SLV_OVERRUN_EN adds the sticky rx_overrun flag output.
module spi_slave_fullduplex #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ack,
`ifdef SPI_SLV_OVERRUN_EN
  output logic             rx_overrun,
`endif
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  // Input synchronisers (p0) and one-cycle-delayed copies for edge detection (p1)
  logic [SYNC_STAGES-1:0] sclk_p0;
  logic [SYNC_STAGES-1:0] cs_p0;
  logic [SYNC_STAGES-1:0] mosi_p0;
  logic                   sclk_p1;
  logic                   cs_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_p0 <= '0;
      cs_p0   <= '1;
      mosi_p0 <= '0;
      sclk_p1 <= 1'b0;
      cs_p1   <= 1'b1;
    end else begin
      sclk_p0 <= {sclk_p0[SYNC_STAGES-2:0], sclk};
      cs_p0   <= {cs_p0[SYNC_STAGES-2:0], cs};
      mosi_p0 <= {mosi_p0[SYNC_STAGES-2:0], mosi};
      sclk_p1 <= sclk_p0[SYNC_STAGES-1];
      cs_p1   <= cs_p0[SYNC_STAGES-1];
    end
  end

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_fall;
  logic cs_fall;
  logic cs_rise;

  assign sclk_s    = sclk_p0[SYNC_STAGES-1];
  assign cs_s      = cs_p0[SYNC_STAGES-1];
  assign mosi_s    = mosi_p0[SYNC_STAGES-1];
  assign sclk_fall = sclk_p1 & ~sclk_s;
  assign cs_fall   = cs_p1 & ~cs_s;
  assign cs_rise   = ~cs_p1 & cs_s;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_cnt_nxt;
  logic [WIDTH-1:0] rx_shift;
  logic [WIDTH-1:0] rx_shift_nxt;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] tx_shift_nxt;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] hold_nxt;
  logic             tx_ready_nxt;
  logic [WIDTH-1:0] rx_data_nxt;
  logic             rx_valid_nxt;
  logic             reload;
  logic             complete;
  logic [WIDTH-1:0] rx_word;

  assign rx_word = {rx_shift[WIDTH-2:0], mosi_s};

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    rx_shift_nxt = rx_shift;
    tx_shift_nxt = tx_shift;
    hold_nxt     = hold;
    tx_ready_nxt = tx_ready;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = rx_valid;
    reload       = 1'b0;
    complete     = 1'b0;

    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt   = SHIFT;
          bit_cnt_nxt = '0;
          reload      = 1'b1;
        end
      end
      SHIFT: begin
        if (sclk_fall) begin
          rx_shift_nxt = rx_word;
          if (bit_cnt == CNT_W'(WIDTH - 1)) begin
            rx_data_nxt = rx_word;
            complete    = 1'b1;
            bit_cnt_nxt = '0;
            reload      = 1'b1;
          end else begin
            bit_cnt_nxt  = bit_cnt + 1'b1;
            tx_shift_nxt = {tx_shift[WIDTH-2:0], 1'b0};
          end
        end
        // A partial word is simply dropped: the counter restarts on the next frame
        if (cs_rise) begin
          state_nxt   = IDLE;
          bit_cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Reload consumes the current holding contents; a same-cycle tx_load stays pending
    if (reload) begin
      tx_shift_nxt = tx_ready ? '0 : hold;
      tx_ready_nxt = 1'b1;
    end
    if (tx_load) begin
      hold_nxt     = tx_data;
      tx_ready_nxt = 1'b0;
    end

    if (rx_ack)   rx_valid_nxt = 1'b0;
    if (complete) rx_valid_nxt = 1'b1;
  end

  // Frame state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      hold     <= '0;
      tx_ready <= 1'b1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      rx_shift <= rx_shift_nxt;
      tx_shift <= tx_shift_nxt;
      hold     <= hold_nxt;
      tx_ready <= tx_ready_nxt;
      rx_data  <= rx_data_nxt;
      rx_valid <= rx_valid_nxt;
    end
  end

`ifdef SPI_SLV_OVERRUN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_overrun <= 1'b0;
    end else if (complete && rx_valid && !rx_ack) begin
      rx_overrun <= 1'b1;
    end else if (rx_ack) begin
      rx_overrun <= 1'b0;
    end
  end
`endif

  assign busy = (state == SHIFT);
  assign miso = (state == SHIFT) & tx_shift[WIDTH-1];

endmodule

// File: tb/tb_spi_slave_fullduplex.sv
// Bench for spi_slave_fullduplex: a behavioural mode-0 master drives frames from a vector
// table and hand-written sequences; received words are checked through a scoreboard queue.
module tb_spi_slave_fullduplex;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] tx_data = '0;
  logic       tx_load = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       busy;
`ifdef SPI_SLV_OVERRUN_EN
  logic       rx_overrun;
`endif

  spi_slave_fullduplex #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
`ifdef SPI_SLV_OVERRUN_EN
    .rx_overrun(rx_overrun),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] tx;
    logic       load;
    logic [7:0] mosi_w;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rx(input string name);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s got %0h expected <scoreboard empty>", name, rx_data);
    end else begin
      e = exp_q.pop_front();
      check(name, {24'd0, rx_data}, {24'd0, e});
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] w);
    tx_data = w;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    tx_data = '0;
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
  endtask

  // Master: update mosi and sample miso at sclk rise; lat = clk cycles from last fall to rx_valid
  task automatic xfer(input logic [7:0] w, input int nbits, output logic [7:0] got, output int lat);
    got = '0;
    lat = -1;
    for (int k = 0; k < nbits; k++) begin
      got[7-k] = miso;
      mosi = w[7-k];
      sclk = 1'b1;
      wait_clk(8);
      sclk = 1'b0;
      if (k == 7) begin
        for (int c = 1; c <= 8; c++) begin
          @(negedge clk);
          if (rx_valid && lat < 0) lat = c;
        end
      end else begin
        wait_clk(8);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] got;
    int lat;

    vecs[0] = '{tx: 8'hA5, load: 1'b1, mosi_w: 8'h3C, exp_rx: 8'h3C, exp_miso: 8'hA5};
    vecs[1] = '{tx: 8'h00, load: 1'b0, mosi_w: 8'h55, exp_rx: 8'h55, exp_miso: 8'h00};
    vecs[2] = '{tx: 8'hFF, load: 1'b1, mosi_w: 8'h00, exp_rx: 8'h00, exp_miso: 8'hFF};
    vecs[3] = '{tx: 8'h80, load: 1'b1, mosi_w: 8'h01, exp_rx: 8'h01, exp_miso: 8'h80};
    vecs[4] = '{tx: 8'h01, load: 1'b1, mosi_w: 8'hFE, exp_rx: 8'hFE, exp_miso: 8'h01};

    wait_clk(3);
    check("reset_miso", {31'd0, miso}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    wait_clk(4);

    // Table-driven single frames
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].load) load_tx(vecs[v].tx);
      check("tx_ready_pre", {31'd0, tx_ready}, {31'd0, ~vecs[v].load});
      cs = 1'b0;
      wait_clk(8);
      check("tx_ready_cs_fall", {31'd0, tx_ready}, 32'd1);
      check("busy_frame", {31'd0, busy}, 32'd1);
      exp_q.push_back(vecs[v].exp_rx);
      xfer(vecs[v].mosi_w, 8, got, lat);
      check("master_rx", {24'd0, got}, {24'd0, vecs[v].exp_miso});
      check("rx_valid", {31'd0, rx_valid}, 32'd1);
      check("rx_latency", lat, 32'd3);
      check_rx("rx_data");
`ifdef SPI_SLV_OVERRUN_EN
      check("overrun_clear", {31'd0, rx_overrun}, 32'd0);
`endif
      cs = 1'b1;
      wait_clk(8);
      check("busy_idle", {31'd0, busy}, 32'd0);
      ack();
      check("rx_valid_ack", {31'd0, rx_valid}, 32'd0);
    end

    // Back-to-back words under one cs, 0x5A loaded during the first word
    load_tx(8'hA5);
    cs = 1'b0;
    wait_clk(8);
    check("b2b_tx_ready_after_fall", {31'd0, tx_ready}, 32'd1);
    load_tx(8'h5A);
    check("b2b_tx_ready_loaded", {31'd0, tx_ready}, 32'd0);
    exp_q.push_back(8'h11);
    xfer(8'h11, 8, got, lat);
    check("b2b_master_rx0", {24'd0, got}, 32'hA5);
    check_rx("b2b_rx_data0");
    check("b2b_tx_ready_reloaded", {31'd0, tx_ready}, 32'd1);
    ack();
    exp_q.push_back(8'h22);
    xfer(8'h22, 8, got, lat);
    check("b2b_master_rx1", {24'd0, got}, 32'h5A);
    check("b2b_rx_valid1", {31'd0, rx_valid}, 32'd1);
    check_rx("b2b_rx_data1");
    cs = 1'b1;
    wait_clk(8);
    ack();

    // Aborted partial frame, then a clean one
    cs = 1'b0;
    wait_clk(8);
    xfer(8'hFF, 5, got, lat);
    cs = 1'b1;
    wait_clk(8);
    check("partial_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("partial_busy", {31'd0, busy}, 32'd0);
    cs = 1'b0;
    wait_clk(8);
    exp_q.push_back(8'h81);
    xfer(8'h81, 8, got, lat);
    check("after_partial_rx_valid", {31'd0, rx_valid}, 32'd1);
    check_rx("after_partial_rx_data");
    check("after_partial_master_rx", {24'd0, got}, 32'h00);
    cs = 1'b1;
    wait_clk(8);
    ack();

    // Two frames without rx_ack
    cs = 1'b0;
    wait_clk(8);
    exp_q.push_back(8'h12);
    xfer(8'h12, 8, got, lat);
    check_rx("ovr_rx_data0");
    cs = 1'b1;
    wait_clk(8);
    cs = 1'b0;
    wait_clk(8);
    exp_q.push_back(8'h34);
    xfer(8'h34, 8, got, lat);
    check_rx("ovr_rx_data1");
    check("ovr_rx_valid", {31'd0, rx_valid}, 32'd1);
`ifdef SPI_SLV_OVERRUN_EN
    check("ovr_flag_set", {31'd0, rx_overrun}, 32'd1);
`endif
    cs = 1'b1;
    wait_clk(8);
    ack();
    check("ovr_rx_valid_ack", {31'd0, rx_valid}, 32'd0);
`ifdef SPI_SLV_OVERRUN_EN
    check("ovr_flag_ack", {31'd0, rx_overrun}, 32'd0);
`endif

    // Asynchronous reset in the middle of a frame
    cs = 1'b0;
    wait_clk(8);
    exp_q.push_back(8'h5C);
    xfer(8'h5C, 8, got, lat);
    check_rx("pre_reset_rx_data");
    cs = 1'b1;
    wait_clk(8);
    load_tx(8'h77);
    cs = 1'b0;
    wait_clk(8);
    xfer(8'hC3, 3, got, lat);
    check("pre_reset_miso", {31'd0, miso}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_miso", {31'd0, miso}, 32'd0);
    check("async_rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("async_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("async_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    cs = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    cs = 1'b0;
    wait_clk(8);
    exp_q.push_back(8'hC3);
    xfer(8'hC3, 8, got, lat);
    check("post_reset_rx_valid", {31'd0, rx_valid}, 32'd1);
    check_rx("post_reset_rx_data");
    check("post_reset_master_rx", {24'd0, got}, 32'h00);
    cs = 1'b1;
    wait_clk(8);
    ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_fullduplex.md
Name: spi_slave_fullduplex

Overview:
- SPI slave stage that sits directly downstream of the team's SPI full-duplex master, on the far end of the mosi/miso/sclk/cs wires.
- Oversamples sclk, cs and mosi with the system clock.
- Deserialises mosi into parallel receive words and serialises a parallel transmit word onto miso.
- Mode 0 framing, MSB first, matching the master (master updates mosi and samples miso on sclk rising).

Parameters:
- WIDTH, 8, bits per frame word.
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers (must be ≥2).

Ports:
- clk  input  1  system clock; must be ≥8× sclk frequency.
- rst_n  input  1  asynchronous active-low reset.
- sclk  input  1  SPI clock from master (asynchronous).
- cs  input  1  chip select from master, active low (asynchronous).
- mosi  input  1  serial data from master.
- miso  output  1  serial data to master.
- tx_data  input  WIDTH  word to shift out on the next frame.
- tx_load  input  1  one-cycle strobe; captures tx_data into the holding register.
- tx_ready  output  1  high when the holding register is empty and may be loaded.
- rx_data  output  WIDTH  last complete received word.
- rx_valid  output  1  high from word completion until rx_ack.
- rx_ack  input  1  one-cycle strobe; clears rx_valid.
- busy  output  1  high while synchronised cs is low.

Behaviour:
- Reset (rst_n=0, asynchronous): miso=0, rx_data=0, rx_valid=0, tx_ready=1, busy=0.
  - Bit counter=0, shift registers=0, holding register=0, state IDLE.
  - Synchronisers reset to sclk=0, cs=1, mosi=0.
- Edge detection: registered copies of the synchronised sclk/cs give one-cycle pulses sclk_rise, sclk_fall, cs_fall, cs_rise. All logic is in the clk domain.
- States:
  - IDLE: busy=0, miso=0. On cs_fall → SHIFT.
    - Load tx_shift from the holding register (or all zeros if tx_ready=1, i.e. empty) and set tx_ready=1.
    - Drive miso = tx_shift MSB the same cycle; bit_cnt=0.
  - SHIFT: busy=1.
    - On sclk_fall: rx_shift <= {rx_shift[WIDTH-2:0], mosi_sync}; bit_cnt++.
      - If bit_cnt was WIDTH-1, the word is complete: rx_data <= assembled word, rx_valid=1, bit_cnt=0.
      - Also reload tx_shift from the holding register (zeros if empty), set tx_ready=1, and present the new MSB on miso. This supports back-to-back frames under one cs.
    - Otherwise on sclk_fall: shift tx_shift left; miso = next bit.
    - sclk_rise: no state change.
    - On cs_rise → IDLE; a partial word (bit_cnt≠0) is discarded with no rx_valid.
- Holding register: tx_load writes tx_data and clears tx_ready. A tx_load while tx_ready=0 overwrites the pending word.
  - If tx_load coincides with a reload, the reload takes the old contents and the new word stays pending (tx_ready=0).
- rx_valid:
  - rx_ack clears it.
  - If word completion and rx_ack occur in the same cycle, completion wins (rx_valid stays 1, rx_data updates).
  - Completion while rx_valid=1 overwrites rx_data.
- sclk edges while cs is high are ignored.
- Latency: rx_valid rises SYNC_STAGES+1 clk after the final sclk falling edge reaches the pin.

Optional Feature:
- Macro SPI_SLV_OVERRUN_EN.
- Defined: adds output port rx_overrun (1 bit, reset 0).
  - Set when a word completes while rx_valid=1 and rx_ack is not asserted in that cycle.
  - rx_data is still overwritten.
  - Cleared only by rx_ack.
- Undefined: port absent; overwrite is silent.

Test Plan:
- After reset, load tx_data=8'hA5 and run a master frame sending 8'h3C: rx_data=8'h3C, rx_valid=1, master receives 8'hA5, tx_ready=1 after cs_fall.
- Two back-to-back words under one cs (0x11 then 0x22), reloading 0x5A after the first word: rx_data sequence 0x11 then 0x22, and the master receives 0xA5 then 0x5A.
- Raise cs after 5 bits of 0xFF: no rx_valid, busy=0, bit_cnt=0. The next full frame of 0x81 gives rx_data=0x81.
- With tx_ready=1 (no load), run one frame: miso is all zeros, master reads 0x00.
- Receive two frames without rx_ack: rx_data holds the second word. With SPI_SLV_OVERRUN_EN, rx_overrun=1, and rx_ack clears both rx_overrun and rx_valid.
- Assert rst_n=0 mid-frame at bit 3: all outputs reach reset values immediately. After release, a clean frame of 0xC3 is received correctly.
